// File: rtl/muxtwo_arbiter.sv
// muxtwo_arbiter: round-robin controller sharing a 2:1 select mux between
// requesters A and B, with bounded bursts and a registered valid/ready
// output stage feeding a single downstream consumer.
module muxtwo_arbiter #(
   parameter int WIDTH     = 1,
   parameter int MAX_BURST = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic [WIDTH-1:0] data_a,
   output logic             ack_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] data_b,
   output logic             ack_b,
   output logic             sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   // Grant encoding keeps sel as a single flop bit (bit 1), so the mux
   // select never glitches when the grant hands over between sides.
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_GNT_A = 2'b01;
   localparam logic [1:0] S_GNT_B = 2'b10;

   // Count value of the final beat of a burst.
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   logic [1:0]       r_state;
   logic             r_last;       // 0 = A granted last, 1 = B granted last
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;

   logic [1:0]       w_next_state;
   logic             w_next_last;
   logic [CNT_W-1:0] w_next_cnt;
   logic             w_load_en;
   logic             w_ack_a;
   logic             w_ack_b;
   logic             w_burst_done;

   assign w_load_en    = !r_out_valid || out_ready;
   assign w_ack_a      = (r_state == S_GNT_A) && req_a && w_load_en;
   assign w_ack_b      = (r_state == S_GNT_B) && req_b && w_load_en;
   assign w_burst_done = (r_cnt == BURST_LAST);

   assign ack_a     = w_ack_a;
   assign ack_b     = w_ack_b;
   assign sel       = r_state[1];
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (r_state != S_IDLE) || r_out_valid;

   // Next grant, last-granted side and burst count.
   always_comb begin
      w_next_state = r_state;
      w_next_last  = r_last;
      w_next_cnt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (req_a && (!req_b || r_last)) begin
               w_next_state = S_GNT_A;
               w_next_last  = 1'b0;
               w_next_cnt   = '0;
            end else if (req_b) begin
               w_next_state = S_GNT_B;
               w_next_last  = 1'b1;
               w_next_cnt   = '0;
            end
         end
         S_GNT_A: begin
            if (!req_a) begin
               w_next_cnt = '0;
               if (req_b) begin
                  w_next_state = S_GNT_B;
                  w_next_last  = 1'b1;
               end else begin
                  w_next_state = S_IDLE;
               end
            end else if (w_ack_a) begin
               if (w_burst_done) begin
                  w_next_cnt = '0;
                  if (req_b) begin
                     w_next_state = S_GNT_B;
                     w_next_last  = 1'b1;
                  end
               end else begin
                  w_next_cnt = r_cnt + 1'b1;
               end
            end
         end
         S_GNT_B: begin
            if (!req_b) begin
               w_next_cnt = '0;
               if (req_a) begin
                  w_next_state = S_GNT_A;
                  w_next_last  = 1'b0;
               end else begin
                  w_next_state = S_IDLE;
               end
            end else if (w_ack_b) begin
               if (w_burst_done) begin
                  w_next_cnt = '0;
                  if (req_a) begin
                     w_next_state = S_GNT_A;
                     w_next_last  = 1'b0;
                  end
               end else begin
                  w_next_cnt = r_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
         end
      endcase
   end

   // Arbitration state registers; last resets to B so A wins the first tie.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next_state;
         r_last  <= w_next_last;
         r_cnt   <= w_next_cnt;
      end
   end

   // Output stage: load on an ack, otherwise drain when downstream takes it.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_ack_a || w_ack_b) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_ack_b ? data_b : data_a;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

endmodule
